// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and MEM-stage data access.
// Optional fetch starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LAT        = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              halt_req,
    output logic              halted,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              proto_err
);

    // Handshake: a request is a level held until its one-cycle valid pulse; the pulse is the only reply.
    typedef enum logic [1:0] {IDLE, BUSY, HALTED} state_t;

    if (LAT < 1 || LAT > 7 || MAX_STARVE < 1 || MAX_STARVE > 7) begin : g_param_check
        $error("mem_port_arbiter: LAT and MAX_STARVE must be in 1..7");
    end

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic       owner_dm;
    logic       op_wr;
    logic       flush_seen;
    logic       halt_seen;
    logic       dm_req;
    logic       fetch_wins;
    logic       grant_dm, grant_if, grant;
    logic       done;

    assign dm_req = dm_rd | dm_wr;
    assign grant  = grant_dm | grant_if;
    assign done   = (state == BUSY) && (cnt == 3'd0);

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] starve_cnt;

    // Counts data grants that overtook a waiting fetch; at the limit the fetch goes first.
    assign fetch_wins = if_req && (starve_cnt == 3'(MAX_STARVE));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_dm && if_req) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end
`else
    assign fetch_wins = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        grant_dm  = 1'b0;
        grant_if  = 1'b0;
        case (state)
            IDLE: begin
                if (halt_req) begin
                    state_nxt = HALTED;
                end else if (dm_req && !fetch_wins) begin
                    grant_dm  = 1'b1;
                    state_nxt = BUSY;
                end else if (if_req) begin
                    grant_if  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    state_nxt = (halt_seen || halt_req) ? HALTED : IDLE;
                end
            end
            HALTED:  state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            owner_dm   <= 1'b0;
            op_wr      <= 1'b0;
            flush_seen <= 1'b0;
            halt_seen  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_en    <= grant;
            mem_we    <= grant_dm && dm_wr;
            mem_wdata <= (grant_dm && dm_wr) ? dm_wdata : '0;
            if (grant) begin
                mem_addr   <= grant_dm ? dm_addr : if_addr;
                owner_dm   <= grant_dm;
                op_wr      <= grant_dm && dm_wr;
                cnt        <= 3'(LAT);
                flush_seen <= 1'b0;
                halt_seen  <= 1'b0;
            end else if (state == BUSY) begin
                if (cnt != 3'd0) begin
                    cnt <= cnt - 3'd1;
                end
                if (!owner_dm && if_flush) begin
                    flush_seen <= 1'b1;
                end
                if (halt_req) begin
                    halt_seen <= 1'b1;
                end
            end
            if (grant_dm && dm_rd && dm_wr) begin
                proto_err <= 1'b1;
            end
        end
    end

    // A flushed fetch still occupies the memory; only its reply is squashed.
    assign if_valid = done && !owner_dm && !flush_seen && !if_flush;
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign dm_valid = done && owner_dm;
    assign dm_rdata = (dm_valid && !op_wr) ? mem_rdata : '0;

    assign halted   = (state == HALTED);
    assign stall_if = if_req & ~if_valid;
    assign stall_dm = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus concurrent random fetch/data traffic,
// with per-requester expected queues consumed by an independent monitor.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int TB_LAT        = 1;
    localparam int TB_MAX_STARVE = 4;
    localparam int TIMEOUT       = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_rd, dm_wr;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        halt_req, halted;
    logic        stall_if, stall_dm, proto_err;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        if_q[$];
    exp_t        dm_q[$];
    logic [31:0] ref_img [0:255];
    bit          proto_exp;
    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .LAT(TB_LAT), .MAX_STARVE(TB_MAX_STARVE)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .halt_req(halt_req), .halted(halted),
        .stall_if(stall_if), .stall_dm(stall_dm), .proto_err(proto_err)
    );

    function automatic logic [31:0] init_val(input int idx);
        logic [7:0] b;
        b = idx[7:0];
        if (idx == 16) return 32'h00A0_0093;
        return {8'hC3, b, ~b, 8'h3C};
    endfunction

    // Fixed-latency memory: read data appears LAT cycles after the command cycle, filler otherwise.
    logic [31:0] mem_img [0:255];
    logic [31:0] rd_pipe [0:TB_LAT-1];
    assign mem_rdata = rd_pipe[TB_LAT-1];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_img[i] <= init_val(i);
            for (int i = 0; i < TB_LAT; i++) rd_pipe[i] <= 32'h5A5A_5A5A;
        end else begin
            if (mem_en && mem_we) mem_img[mem_addr[9:2]] <= mem_wdata;
            rd_pipe[0] <= (mem_en && !mem_we) ? mem_img[mem_addr[9:2]] : 32'h5A5A_5A5A;
            for (int i = 1; i < TB_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: pops the owner's queue on every valid pulse and checks command, latency and spacing.
    int          prev_en;
    bit          have_prev, cmd_pend;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        cmd_we;

    initial begin : monitor
        exp_t e;
        have_prev = 0;
        cmd_pend  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_prev = 0;
                cmd_pend  = 0;
            end else begin
                if (mem_en) begin
                    if (have_prev) check("mem_en_spacing", {31'd0, (cycle - prev_en) >= TB_LAT + 2}, 32'd1);
                    prev_en   = cycle;
                    have_prev = 1;
                    cmd_pend  = 1;
                    cmd_addr  = mem_addr;
                    cmd_we    = mem_we;
                    cmd_wdata = mem_wdata;
                end else begin
                    check("mem_we_without_en", {31'd0, mem_we}, 32'd0);
                end
                check("dual_valid", {31'd0, if_valid & dm_valid}, 32'd0);
                if (if_valid) begin
                    check("if_latency", cmd_pend ? 32'(cycle - prev_en) : 32'hFFFF_FFFF, TB_LAT);
                    if (if_q.size() == 0) begin
                        check("if_unexpected_valid", {31'd0, if_valid}, 32'd0);
                    end else begin
                        e = if_q.pop_front();
                        check("if_cmd_addr", cmd_addr, e.addr);
                        check("if_cmd_we", {31'd0, cmd_we}, 32'd0);
                        check("if_rdata", if_rdata, e.rdata);
                    end
                    cmd_pend = 0;
                end else begin
                    check("if_rdata_idle", if_rdata, 32'd0);
                end
                if (dm_valid) begin
                    check("dm_latency", cmd_pend ? 32'(cycle - prev_en) : 32'hFFFF_FFFF, TB_LAT);
                    if (dm_q.size() == 0) begin
                        check("dm_unexpected_valid", {31'd0, dm_valid}, 32'd0);
                    end else begin
                        e = dm_q.pop_front();
                        check("dm_cmd_addr", cmd_addr, e.addr);
                        check("dm_cmd_we", {31'd0, cmd_we}, {31'd0, e.we});
                        if (e.we) check("dm_cmd_wdata", cmd_wdata, e.wdata);
                        check("dm_rdata", dm_rdata, e.rdata);
                    end
                    cmd_pend = 0;
                end else begin
                    check("dm_rdata_idle", dm_rdata, 32'd0);
                end
                check("stall_if", {31'd0, stall_if}, {31'd0, if_req & ~if_valid});
                check("stall_dm", {31'd0, stall_dm}, {31'd0, (dm_rd | dm_wr) & ~dm_valid});
            end
        end
    end

    task automatic reset_ref();
        for (int i = 0; i < 256; i++) ref_img[i] = init_val(i);
        proto_exp = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; if_req = 0; if_flush = 0; if_addr = 0;
        dm_rd = 0; dm_wr = 0; dm_addr = 0; dm_wdata = 0; halt_req = 0;
        reset_ref();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic fetch(input logic [31:0] addr);
        exp_t e;
        bit   ok;
        e.addr = addr; e.we = 0; e.wdata = 0; e.rdata = ref_img[addr[9:2]];
        if_q.push_back(e);
        if_addr = addr;
        if_req  = 1;
        ok = 0;
        for (int t = 0; t < TIMEOUT && !ok; t++) begin
            @(negedge clk);
            if (if_valid) ok = 1;
        end
        check("if_handshake_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        if_req = 0;
    endtask

    task automatic data_access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        bit   ok;
        e.addr = addr; e.we = wr; e.wdata = wr ? wdata : 32'd0;
        e.rdata = wr ? 32'd0 : ref_img[addr[9:2]];
        if (wr) ref_img[addr[9:2]] = wdata;
        if (rd && wr) proto_exp = 1;
        dm_q.push_back(e);
        dm_addr = addr; dm_wdata = wdata; dm_rd = rd; dm_wr = wr;
        ok = 0;
        for (int t = 0; t < TIMEOUT && !ok; t++) begin
            @(negedge clk);
            if (dm_valid) ok = 1;
        end
        check("dm_handshake_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        dm_rd = 0; dm_wr = 0;
    endtask

    function automatic bit fetch_turn(input int k);
`ifdef ARB_STARVE_GUARD_EN
        return (k % (TB_MAX_STARVE + 1)) == TB_MAX_STARVE;
`else
        return (k < 0);
`endif
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : main
        exp_t e;
        int   n;
        bit   got;
        do_reset();

        // Reset state and lone fetch.
        @(negedge clk);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        check("rst_valids", {30'd0, if_valid, dm_valid}, 32'd0);
        @(posedge clk); #1;
        e.addr = 32'h40; e.we = 0; e.wdata = 0; e.rdata = 32'h00A0_0093;
        if_q.push_back(e);
        if_addr = 32'h40; if_req = 1;
        @(negedge clk);
        check("t1_no_en_in_decision", {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        check("t1_mem_en", {31'd0, mem_en}, 32'd1);
        check("t1_mem_addr", mem_addr, 32'h40);
        @(negedge clk);
        check("t1_if_valid", {31'd0, if_valid}, 32'd1);
        check("t1_if_rdata", if_rdata, 32'h00A0_0093);
        @(posedge clk); #1;
        if_req = 0;
        @(negedge clk);
        check("t1_stall_if_after", {31'd0, stall_if}, 32'd0);
        @(posedge clk); #1;

        // Simultaneous fetch and data read: data first, fetch three cycles later.
        e.addr = 32'h100; e.we = 0; e.wdata = 0; e.rdata = ref_img[64];
        dm_q.push_back(e);
        e.addr = 32'h44; e.rdata = ref_img[17];
        if_q.push_back(e);
        if_addr = 32'h44; if_req = 1; dm_addr = 32'h100; dm_rd = 1;
        @(negedge clk);
        @(negedge clk);
        check("t2_data_first_en", {31'd0, mem_en}, 32'd1);
        check("t2_data_first_addr", mem_addr, 32'h100);
        @(negedge clk);
        check("t2_dm_valid", {31'd0, dm_valid}, 32'd1);
        @(posedge clk); #1;
        dm_rd = 0;
        @(negedge clk);
        check("t2_idle_gap", {31'd0, mem_en}, 32'd0);
        @(negedge clk);
        check("t2_fetch_en", {31'd0, mem_en}, 32'd1);
        check("t2_fetch_addr", mem_addr, 32'h44);
        @(negedge clk);
        @(posedge clk); #1;
        if_req = 0;

        // Data write, then read back.
        e.addr = 32'h200; e.we = 1; e.wdata = 32'hDEAD_BEEF; e.rdata = 0;
        dm_q.push_back(e);
        ref_img[128] = 32'hDEAD_BEEF;
        dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF; dm_wr = 1;
        @(negedge clk);
        @(negedge clk);
        check("t3_mem_we", {31'd0, mem_we}, 32'd1);
        check("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        check("t3_mem_we_one_cycle", {31'd0, mem_we}, 32'd0);
        check("t3_mem_wdata_one_cycle", mem_wdata, 32'd0);
        check("t3_dm_valid", {31'd0, dm_valid}, 32'd1);
        check("t3_dm_rdata_zero", dm_rdata, 32'd0);
        @(posedge clk); #1;
        dm_wr = 0;
        gap(1);
        data_access(1, 0, 32'h200, 32'd0);

        // Flush while the fetch is in flight, then in its completion cycle.
        if_addr = 32'h48; if_req = 1;
        @(posedge clk); #1;
        if_flush = 1; if_req = 0;
        @(posedge clk); #1;
        if_flush = 0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if_valid) n++;
        end
        check("t4_flush_busy_no_valid", 32'(n), 32'd0);
        @(posedge clk); #1;
        fetch(32'h4C);
        gap(1);
        if_addr = 32'h58; if_req = 1;
        gap(2);
        if_flush = 1; if_req = 0;
        @(negedge clk);
        check("t4_flush_done_no_valid", {31'd0, if_valid}, 32'd0);
        check("t4_flush_done_rdata", if_rdata, 32'd0);
        @(posedge clk); #1;
        if_flush = 0;
        gap(2);
        fetch(32'h50);

        // Halt during a busy data read.
        e.addr = 32'h104; e.we = 0; e.wdata = 0; e.rdata = ref_img[65];
        dm_q.push_back(e);
        dm_addr = 32'h104; dm_rd = 1;
        @(posedge clk); #1;
        halt_req = 1;
        @(posedge clk); #1;
        halt_req = 0;
        @(negedge clk);
        check("t5_dm_valid", {31'd0, dm_valid}, 32'd1);
        check("t5_not_yet_halted", {31'd0, halted}, 32'd0);
        @(posedge clk); #1;
        dm_rd = 0; if_addr = 32'h5C; if_req = 1;
        @(negedge clk);
        check("t5_halted", {31'd0, halted}, 32'd1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_en || if_valid) n++;
        end
        check("t5_no_grant_when_halted", 32'(n), 32'd0);
        check("t5_halted_sticky", {31'd0, halted}, 32'd1);
        do_reset();
        @(negedge clk);
        check("t5_rst_clears_halted", {31'd0, halted}, 32'd0);
        @(posedge clk); #1;

        // Halt seen in IDLE blocks the pending request.
        halt_req = 1; dm_addr = 32'h108; dm_rd = 1;
        @(negedge clk);
        @(negedge clk);
        check("t5b_halted", {31'd0, halted}, 32'd1);
        check("t5b_no_mem_en", {31'd0, mem_en}, 32'd0);
        do_reset();

        // Read and write together: executed as a write, proto_err sticky until reset.
        data_access(1, 1, 32'h208, 32'h1234_5678);
        check("proto_err_set", {31'd0, proto_err}, {31'd0, proto_exp});
        data_access(1, 0, 32'h208, 32'd0);
        check("proto_err_sticky", {31'd0, proto_err}, 32'd1);
        do_reset();
        @(negedge clk);
        check("proto_err_cleared", {31'd0, proto_err}, 32'd0);

        // Both requesters held high: grant pattern follows the priority rule.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (fetch_turn(k)) begin
                e.addr = 32'h60; e.we = 0; e.wdata = 0; e.rdata = ref_img[24];
                if_q.push_back(e);
            end else begin
                e.addr = 32'h10C; e.we = 0; e.wdata = 0; e.rdata = ref_img[67];
                dm_q.push_back(e);
            end
        end
        dm_addr = 32'h10C; dm_rd = 1; if_addr = 32'h60; if_req = 1;
        for (int k = 0; k < 10; k++) begin
            got = 0;
            for (int t = 0; t < 50 && !got; t++) begin
                @(negedge clk);
                if (mem_en) got = 1;
            end
            check("t6_grant_seen", {31'd0, got}, 32'd1);
            check("t6_grant_addr", mem_addr, fetch_turn(k) ? 32'h60 : 32'h10C);
        end
        @(posedge clk); #1;
        dm_rd = 0; if_req = 0;
        gap(4);
        check("t6_if_q_drained", 32'(if_q.size()), 32'd0);
        check("t6_dm_q_drained", 32'(dm_q.size()), 32'd0);

        // Random concurrent traffic from both requesters.
        do_reset();
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    gap($urandom_range(0, 3));
                    fetch(32'($urandom_range(0, 63)) << 2);
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    int          kind;
                    logic [31:0] a;
                    gap($urandom_range(0, 3));
                    kind = $urandom_range(0, 15);
                    a    = 32'($urandom_range(64, 255)) << 2;
                    data_access(kind == 0 || kind > 6, kind <= 6, a, $urandom);
                end
            end
        join
        gap(4);
        check("rand_proto_err", {31'd0, proto_err}, {31'd0, proto_exp});
        check("rand_if_q_drained", 32'(if_q.size()), 32'd0);
        check("rand_dm_q_drained", 32'(dm_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
